ram_curr_mem: RTL and testbench

//  Per-read storage for the SMEM pipeline: a dual-port "curr" queue (ik intervals) and a dual-port "mem" queue
//  (p intervals), each holding up to 128 x 256-bit entries per read of a batch. Also latches per-read ret and
//  mem_size. Once every read in the batch reports both, it requests the output bus and streams results as 512-bit lines.

---
 rtl/ram_curr_mem_pkg.sv | 24 ++
 rtl/ram_curr_mem_ram_dp_256.sv | 33 +++
 rtl/ram_curr_mem.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_curr_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_curr_mem_pkg.sv
// Shared widths, output-line header layout and output-engine states for ram_curr_mem.
package ram_curr_mem_pkg;

  localparam int unsigned ENTRY_W   = 256;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned RN_FULL_W = 10;
  localparam int unsigned BATCH_W   = 9;
  localparam int unsigned RET_W     = 32;
  localparam int unsigned SIZE_W    = 7;

  // Header line: {zeros, read index, mem size, ret}
  localparam int unsigned HDR_RET_LSB  = 0;
  localparam int unsigned HDR_SIZE_LSB = 32;
  localparam int unsigned HDR_RN_LSB   = 39;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_DONE
  } out_state_e;

endpackage

// File: rtl/ram_curr_mem_ram_dp_256.sv
// ram_dp_256: true dual-port 256-bit RAM, read-first, registered q, no reset.
//  i_clk            clock
//  i_we_a/i_we_b    write enable (else read)
//  i_addr_a/i_addr_b entry address
//  i_data_a/i_data_b write data
//  o_q_a/o_q_b      read data, one cycle after the address
module ram_dp_256
  import ram_curr_mem_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic               i_clk,
  input  logic               i_we_a,
  input  logic [AW-1:0]      i_addr_a,
  input  logic [ENTRY_W-1:0] i_data_a,
  output logic [ENTRY_W-1:0] o_q_a,
  input  logic               i_we_b,
  input  logic [AW-1:0]      i_addr_b,
  input  logic [ENTRY_W-1:0] i_data_b,
  output logic [ENTRY_W-1:0] o_q_b
);

  logic [ENTRY_W-1:0] r_mem [2**AW];

  // q samples before the write lands (read-first); port A written last so it wins a collision.
  always_ff @(posedge i_clk) begin
    o_q_a <= r_mem[i_addr_a];
    o_q_b <= r_mem[i_addr_b];
    if (i_we_b) r_mem[i_addr_b] <= i_data_b;
    if (i_we_a) r_mem[i_addr_a] <= i_data_a;
  end

endmodule

// File: rtl/ram_curr_mem.sv
// ram_curr_mem: per-read curr/mem queues for the SMEM pipeline, plus per-read ret/mem_size capture.
// When every read of the batch has reported both, requests the output bus and streams, per read,
// a header line followed by the read's mem entries packed two per 512-bit line.
//  curr_* / mem_*     two-port access to the curr and mem queues (mem ports must idle while streaming)
//  ret_* / mem_size_* per-read strobes
//  output_*           request/permit handshake and line stream; stall freezes the stream
module ram_curr_mem
  import ram_curr_mem_pkg::*;
#(
  parameter int unsigned MAX_BATCH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic [BATCH_W-1:0]   batch_size,
  input  logic [RN_FULL_W-1:0] curr_read_num_1,
  input  logic                 curr_we_1,
  input  logic [ENTRY_W-1:0]   curr_data_1,
  input  logic [ADDR_W-1:0]    curr_addr_1,
  output logic [ENTRY_W-1:0]   curr_q_1,
  input  logic [RN_FULL_W-1:0] curr_read_num_2,
  input  logic                 curr_we_2,
  input  logic [ENTRY_W-1:0]   curr_data_2,
  input  logic [ADDR_W-1:0]    curr_addr_2,
  output logic [ENTRY_W-1:0]   curr_q_2,
  input  logic [RN_FULL_W-1:0] mem_read_num_1,
  input  logic                 mem_we_1,
  input  logic [ENTRY_W-1:0]   mem_data_1,
  input  logic [ADDR_W-1:0]    mem_addr_1,
  output logic [ENTRY_W-1:0]   mem_q_1,
  input  logic [RN_FULL_W-1:0] mem_read_num_2,
  input  logic                 mem_we_2,
  input  logic [ENTRY_W-1:0]   mem_data_2,
  input  logic [ADDR_W-1:0]    mem_addr_2,
  output logic [ENTRY_W-1:0]   mem_q_2,
  input  logic                 mem_size_valid,
  input  logic [SIZE_W-1:0]    mem_size,
  input  logic [RN_FULL_W-1:0] mem_size_read_num,
  input  logic                 ret_valid,
  input  logic [RET_W-1:0]     ret,
  input  logic [RN_FULL_W-1:0] ret_read_num,
  output logic                 output_request,
  input  logic                 output_permit,
  output logic [LINE_W-1:0]    output_data,
  output logic                 output_valid,
  output logic                 output_finish
);

  localparam int unsigned RN_W   = $clog2(MAX_BATCH);
  localparam int unsigned AW     = RN_W + ADDR_W;
  localparam int unsigned PAIR_W = ADDR_W - 1;

  logic [RET_W-1:0]     r_ret_reg  [MAX_BATCH];
  logic [SIZE_W-1:0]    r_size_reg [MAX_BATCH];
  logic [RET_W-1:0]     r_ret_snap [MAX_BATCH];
  logic [SIZE_W-1:0]    r_size_snap[MAX_BATCH];
  logic [MAX_BATCH-1:0] r_ret_seen, r_size_seen;

  out_state_e          r_state, w_nxt_state;
  logic [BATCH_W-1:0]  r_rd, w_nxt_rd;
  logic                r_hdr, w_nxt_hdr;
  logic [PAIR_W-1:0]   r_pair, w_nxt_pair;
  logic                w_adv, w_complete, w_read_done, w_last_read, w_pair_end, w_hi_ok;
  logic [LINE_W-1:0]   w_line;
  logic [RET_W-1:0]    w_cur_ret;
  logic [SIZE_W-1:0]   w_cur_size;

  logic                r_out_req, r_out_valid, r_out_finish;
  logic [LINE_W-1:0]   r_out_data;

  logic                w_engine;
  logic                w_mem_we_1, w_mem_we_2;
  logic [AW-1:0]       w_mem_addr_1, w_mem_addr_2;
  logic                w_unused_rn;

  assign w_unused_rn = ^{curr_read_num_1, curr_read_num_2, mem_read_num_1, mem_read_num_2,
                         mem_size_read_num, ret_read_num};

  ram_dp_256 #(.AW(AW)) u_curr (
    .i_clk   (clk),
    .i_we_a  (curr_we_1),
    .i_addr_a({curr_read_num_1[RN_W-1:0], curr_addr_1}),
    .i_data_a(curr_data_1),
    .o_q_a   (curr_q_1),
    .i_we_b  (curr_we_2),
    .i_addr_b({curr_read_num_2[RN_W-1:0], curr_addr_2}),
    .i_data_b(curr_data_2),
    .o_q_b   (curr_q_2)
  );

  // The engine addresses the entries its *next* state will emit, so a held state keeps q stable.
  assign w_engine     = (r_state == ST_SEND);
  assign w_mem_we_1   = w_engine ? 1'b0 : mem_we_1;
  assign w_mem_we_2   = w_engine ? 1'b0 : mem_we_2;
  assign w_mem_addr_1 = w_engine ? {w_nxt_rd[RN_W-1:0], w_nxt_pair, 1'b0}
                                 : {mem_read_num_1[RN_W-1:0], mem_addr_1};
  assign w_mem_addr_2 = w_engine ? {w_nxt_rd[RN_W-1:0], w_nxt_pair, 1'b1}
                                 : {mem_read_num_2[RN_W-1:0], mem_addr_2};

  ram_dp_256 #(.AW(AW)) u_mem (
    .i_clk   (clk),
    .i_we_a  (w_mem_we_1),
    .i_addr_a(w_mem_addr_1),
    .i_data_a(mem_data_1),
    .o_q_a   (mem_q_1),
    .i_we_b  (w_mem_we_2),
    .i_addr_b(w_mem_addr_2),
    .i_data_b(mem_data_2),
    .o_q_b   (mem_q_2)
  );

  // Register files; the stream uses a snapshot so late strobes cannot disturb it.
  always_ff @(posedge clk) begin
    if (ret_valid)      r_ret_reg[ret_read_num[RN_W-1:0]]       <= ret;
    if (mem_size_valid) r_size_reg[mem_size_read_num[RN_W-1:0]] <= mem_size;
    if (r_state == ST_IDLE && w_complete) begin
      r_ret_snap  <= r_ret_reg;
      r_size_snap <= r_size_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ret_seen  <= '0;
      r_size_seen <= '0;
    end else if (r_state == ST_DONE) begin
      r_ret_seen  <= '0;
      r_size_seen <= '0;
    end else begin
      if (ret_valid)      r_ret_seen[ret_read_num[RN_W-1:0]]       <= 1'b1;
      if (mem_size_valid) r_size_seen[mem_size_read_num[RN_W-1:0]] <= 1'b1;
    end
  end

  always_comb begin
    w_complete = (batch_size != '0) && (32'(batch_size) <= MAX_BATCH);
    for (int unsigned i = 0; i < MAX_BATCH; i++) begin
      if ((i < 32'(batch_size)) && !(r_ret_seen[i] && r_size_seen[i])) w_complete = 1'b0;
    end
  end

  assign w_cur_ret  = r_ret_snap[r_rd[RN_W-1:0]];
  assign w_cur_size = r_size_snap[r_rd[RN_W-1:0]];
  assign w_last_read = ((r_rd + 9'd1) == batch_size);
  assign w_pair_end  = ({1'b0, r_pair, 1'b0} + 8'd2) >= {1'b0, w_cur_size};
  assign w_hi_ok     = {1'b0, r_pair, 1'b1} < {1'b0, w_cur_size};

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rd    = r_rd;
    w_nxt_hdr   = r_hdr;
    w_nxt_pair  = r_pair;
    w_adv       = 1'b0;
    w_line      = '0;
    w_read_done = 1'b0;
    case (r_state)
      ST_IDLE: if (w_complete) w_nxt_state = ST_REQ;
      ST_REQ: begin
        if (output_permit) begin
          w_nxt_state = ST_SEND;
          w_nxt_rd    = '0;
          w_nxt_hdr   = 1'b1;
          w_nxt_pair  = '0;
        end
      end
      ST_SEND: begin
        w_adv = output_permit && !stall;
        if (r_hdr) begin
          w_line[HDR_RET_LSB +: RET_W]   = w_cur_ret;
          w_line[HDR_SIZE_LSB +: SIZE_W] = w_cur_size;
          w_line[HDR_RN_LSB +: BATCH_W]  = r_rd;
          w_read_done = (w_cur_size == '0);
        end else begin
          w_line[ENTRY_W-1:0] = mem_q_1;
          if (w_hi_ok) w_line[LINE_W-1:ENTRY_W] = mem_q_2;
          w_read_done = w_pair_end;
        end
        if (w_adv) begin
          if (w_read_done) begin
            if (w_last_read) begin
              w_nxt_state = ST_DONE;
            end else begin
              w_nxt_rd   = r_rd + 9'd1;
              w_nxt_hdr  = 1'b1;
              w_nxt_pair = '0;
            end
          end else if (r_hdr) begin
            w_nxt_hdr  = 1'b0;
            w_nxt_pair = '0;
          end else begin
            w_nxt_pair = r_pair + 6'd1;
          end
        end
      end
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_rd         <= '0;
      r_hdr        <= 1'b0;
      r_pair       <= '0;
      r_out_req    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_finish <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_rd         <= w_nxt_rd;
      r_hdr        <= w_nxt_hdr;
      r_pair       <= w_nxt_pair;
      r_out_req    <= (w_nxt_state == ST_REQ) || (w_nxt_state == ST_SEND) ||
                      (w_nxt_state == ST_DONE);
      r_out_valid  <= w_adv;
      r_out_finish <= (r_state == ST_DONE);
      if (w_adv) r_out_data <= w_line;
    end
  end

  assign output_request = r_out_req;
  assign output_valid   = r_out_valid;
  assign output_finish  = r_out_finish;
  assign output_data    = r_out_data;

endmodule

// File: tb/tb_ram_curr_mem.sv
module tb_ram_curr_mem;

  logic         clk = 0;
  logic         reset_n, stall;
  logic [8:0]   batch_size;
  logic [9:0]   curr_read_num_1, curr_read_num_2, mem_read_num_1, mem_read_num_2;
  logic         curr_we_1, curr_we_2, mem_we_1, mem_we_2;
  logic [255:0] curr_data_1, curr_data_2, mem_data_1, mem_data_2;
  logic [6:0]   curr_addr_1, curr_addr_2, mem_addr_1, mem_addr_2;
  logic [255:0] curr_q_1, curr_q_2, mem_q_1, mem_q_2;
  logic         mem_size_valid, ret_valid;
  logic [6:0]   mem_size;
  logic [9:0]   mem_size_read_num, ret_read_num;
  logic [31:0]  ret;
  logic         output_request, output_permit, output_valid, output_finish;
  logic [511:0] output_data;

  int checks = 0;
  int failures = 0;
  logic [511:0] exp_lines [8];

  always #5 clk = ~clk;

  ram_curr_mem #(.MAX_BATCH(32)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .batch_size(batch_size),
    .curr_read_num_1(curr_read_num_1), .curr_we_1(curr_we_1), .curr_data_1(curr_data_1),
    .curr_addr_1(curr_addr_1), .curr_q_1(curr_q_1),
    .curr_read_num_2(curr_read_num_2), .curr_we_2(curr_we_2), .curr_data_2(curr_data_2),
    .curr_addr_2(curr_addr_2), .curr_q_2(curr_q_2),
    .mem_read_num_1(mem_read_num_1), .mem_we_1(mem_we_1), .mem_data_1(mem_data_1),
    .mem_addr_1(mem_addr_1), .mem_q_1(mem_q_1),
    .mem_read_num_2(mem_read_num_2), .mem_we_2(mem_we_2), .mem_data_2(mem_data_2),
    .mem_addr_2(mem_addr_2), .mem_q_2(mem_q_2),
    .mem_size_valid(mem_size_valid), .mem_size(mem_size), .mem_size_read_num(mem_size_read_num),
    .ret_valid(ret_valid), .ret(ret), .ret_read_num(ret_read_num),
    .output_request(output_request), .output_permit(output_permit), .output_data(output_data),
    .output_valid(output_valid), .output_finish(output_finish)
  );

  typedef struct {
    logic we1; logic [9:0] rn1; logic [6:0] a1; logic [255:0] d1;
    logic we2; logic [9:0] rn2; logic [6:0] a2; logic [255:0] d2;
    bit c1; logic [255:0] e1; bit c2; logic [255:0] e2;
  } cvec_t;

  typedef struct { bit portb; logic [9:0] rn; logic [6:0] a; logic [255:0] d; } mvec_t;
  typedef struct { bit is_ret; logic [9:0] rn; logic [31:0] val; } svec_t;

  function automatic logic [255:0] ent(input int a, input int b, input int c, input int d);
    return {64'(a), 64'(b), 64'(c), 64'(d)};
  endfunction

  function automatic logic [511:0] hdr(input int r, input int s, input int rt);
    return (512'(r) << 39) | (512'(s) << 32) | 512'(rt);
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit is_ret, input logic [9:0] rn, input logic [31:0] val);
    if (is_ret) begin ret_valid = 1; ret_read_num = rn; ret = val; end
    else begin mem_size_valid = 1; mem_size_read_num = rn; mem_size = val[6:0]; end
    tick();
    ret_valid = 0; mem_size_valid = 0;
  endtask

  task automatic collect(input int n_exp, input bit do_stall);
    int n, fin, last_v, fin_c, c;
    bit stalled;
    n = 0; fin = 0; last_v = -1; fin_c = -1; c = 0; stalled = 0;
    while (c < 80 && !(fin_c >= 0 && c > fin_c + 2)) begin
      tick(); c++;
      if (output_valid) begin
        if (n < n_exp) check($sformatf("line%0d", n), output_data, exp_lines[n]);
        n++; last_v = c;
      end
      if (output_finish) begin
        fin++; fin_c = c;
        check("req_low_at_finish", 512'(output_request), 512'(0));
      end
      if (do_stall && !stalled && n == 3) begin
        stalled = 1; stall = 1;
        repeat (2) begin
          tick(); c++;
          check("valid_in_stall", 512'(output_valid), 512'(0));
        end
        stall = 0;
      end
    end
    check("line_count", 512'(n), 512'(n_exp));
    check("finish_count", 512'(fin), 512'(1));
    check("finish_after_last", 512'(fin_c), 512'(last_v + 1));
  endtask

  cvec_t cv [8];
  mvec_t mv [7];
  svec_t sv [6];
  logic [255:0] d1, d2, d3, d4, d5, d6, d7;
  int k;

  initial begin
    reset_n = 0; stall = 0; batch_size = 9'd3; output_permit = 0;
    curr_we_1 = 0; curr_we_2 = 0; mem_we_1 = 0; mem_we_2 = 0;
    curr_read_num_1 = '0; curr_read_num_2 = '0; mem_read_num_1 = '0; mem_read_num_2 = '0;
    curr_addr_1 = '0; curr_addr_2 = '0; mem_addr_1 = '0; mem_addr_2 = '0;
    curr_data_1 = '0; curr_data_2 = '0; mem_data_1 = '0; mem_data_2 = '0;
    mem_size_valid = 0; mem_size = '0; mem_size_read_num = '0;
    ret_valid = 0; ret = '0; ret_read_num = '0;

    d1 = ent(4, 3, 2, 1);     d2 = ent(8, 7, 6, 5);     d3 = ent(44, 33, 22, 11);
    d4 = ent(1, 2, 3, 4);     d5 = ent(55, 54, 53, 52); d6 = ent(66, 65, 64, 63);
    d7 = ent(77, 76, 75, 74);

    repeat (2) tick();
    check("rst_request", 512'(output_request), 512'(0));
    check("rst_valid", 512'(output_valid), 512'(0));
    check("rst_finish", 512'(output_finish), 512'(0));
    check("rst_data", output_data, '0);
    reset_n = 1;
    tick();

    // curr queue: basic, read-first, A-wins collision, top address, read_num aliasing
    cv[0] = '{1, 0, 0, d1, 1, 1, 1, d2, 0, '0, 0, '0};
    cv[1] = '{0, 0, 0, '0, 0, 1, 1, '0, 1, d1, 1, d2};
    cv[2] = '{1, 0, 0, d3, 0, 1, 1, '0, 1, d1, 1, d2};
    cv[3] = '{0, 0, 0, '0, 1, 3, 7, d4, 1, d3, 0, '0};
    cv[4] = '{1, 2, 5, d5, 1, 2, 5, d6, 0, '0, 0, '0};
    cv[5] = '{0, 2, 5, '0, 0, 3, 7, '0, 1, d5, 1, d4};
    cv[6] = '{1, 31, 127, d7, 0, 1, 1, '0, 0, '0, 1, d2};
    cv[7] = '{0, 31, 127, '0, 0, 33, 1, '0, 1, d7, 1, d2};
    for (int i = 0; i < 8; i++) begin
      curr_we_1 = cv[i].we1; curr_read_num_1 = cv[i].rn1; curr_addr_1 = cv[i].a1; curr_data_1 = cv[i].d1;
      curr_we_2 = cv[i].we2; curr_read_num_2 = cv[i].rn2; curr_addr_2 = cv[i].a2; curr_data_2 = cv[i].d2;
      tick();
      if (cv[i].c1) check($sformatf("curr_q_1_v%0d", i), 512'(curr_q_1), 512'(cv[i].e1));
      if (cv[i].c2) check($sformatf("curr_q_2_v%0d", i), 512'(curr_q_2), 512'(cv[i].e2));
    end
    curr_we_1 = 0; curr_we_2 = 0;

    // mem queue contents for the batch
    mv[0] = '{0, 0, 0, ent(4, 3, 2, 1)};
    mv[1] = '{1, 0, 1, ent(28, 27, 26, 25)};
    mv[2] = '{1, 1, 0, ent(8, 7, 6, 5)};
    mv[3] = '{0, 1, 1, ent(12, 11, 10, 9)};
    mv[4] = '{1, 2, 0, ent(16, 15, 14, 13)};
    mv[5] = '{0, 2, 1, ent(20, 19, 18, 17)};
    mv[6] = '{1, 2, 2, ent(24, 23, 22, 21)};
    for (int i = 0; i < 7; i++) begin
      if (mv[i].portb) begin
        mem_we_2 = 1; mem_read_num_2 = mv[i].rn; mem_addr_2 = mv[i].a; mem_data_2 = mv[i].d;
      end else begin
        mem_we_1 = 1; mem_read_num_1 = mv[i].rn; mem_addr_1 = mv[i].a; mem_data_1 = mv[i].d;
      end
      tick();
      mem_we_1 = 0; mem_we_2 = 0;
    end

    // request only once the last of the six strobes has landed
    sv[0] = '{1, 0, 1}; sv[1] = '{1, 1, 2}; sv[2] = '{1, 2, 3};
    sv[3] = '{0, 0, 1}; sv[4] = '{0, 1, 2}; sv[5] = '{0, 2, 3};
    for (int i = 0; i < 6; i++) begin
      strobe(sv[i].is_ret, sv[i].rn, sv[i].val);
      check($sformatf("req_early_s%0d", i), 512'(output_request), 512'(0));
    end
    tick();
    check("req_after_last_strobe", 512'(output_request), 512'(1));

    exp_lines[0] = hdr(0, 1, 1);
    exp_lines[1] = {256'd0, ent(4, 3, 2, 1)};
    exp_lines[2] = hdr(1, 2, 2);
    exp_lines[3] = {ent(12, 11, 10, 9), ent(8, 7, 6, 5)};
    exp_lines[4] = hdr(2, 3, 3);
    exp_lines[5] = {ent(20, 19, 18, 17), ent(16, 15, 14, 13)};
    exp_lines[6] = {256'd0, ent(24, 23, 22, 21)};
    output_permit = 1;
    collect(7, 1);
    output_permit = 0;
    tick();

    // mid-stream reset
    batch_size = 9'd1;
    strobe(1, 0, 9);
    strobe(0, 0, 2);
    for (k = 0; k < 20 && !output_request; k++) tick();
    check("req_rise_b2", 512'(output_request), 512'(1));
    output_permit = 1;
    for (k = 0; k < 20 && !output_valid; k++) tick();
    check("first_line_b2", output_data, hdr(0, 2, 9));
    reset_n = 0;
    #1;
    check("abort_request", 512'(output_request), 512'(0));
    check("abort_valid", 512'(output_valid), 512'(0));
    check("abort_finish", 512'(output_finish), 512'(0));
    check("abort_data", output_data, '0);
    output_permit = 0;
    tick();
    reset_n = 1;
    tick();

    // fresh batch after reset, second read has size 0 (header only)
    batch_size = 9'd2;
    strobe(1, 0, 9);
    strobe(0, 0, 2);
    strobe(1, 1, 7);
    strobe(0, 1, 0);
    exp_lines[0] = hdr(0, 2, 9);
    exp_lines[1] = {ent(28, 27, 26, 25), ent(4, 3, 2, 1)};
    exp_lines[2] = hdr(1, 0, 7);
    output_permit = 1;
    collect(3, 0);
    output_permit = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
